// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - sample-tick divider, 2-flop sync, tick-sampled debounce and rising-edge pulse for set/up/down
module button_conditioner #(
  parameter int DIV     = 250000,
  parameter int SAMPLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic up,
  input  logic down,
  output logic slow_tick,
  output logic db_set,
  output logic db_up,
  output logic db_down,
  output logic pulse_set,
  output logic pulse_up,
  output logic pulse_down
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  // Channel bit order everywhere: {down, up, set}
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                sync1_q, sync1_d;
  logic [2:0]                sync2_q, sync2_d;
  logic [2:0][SAMPLES-1:0]   hist_q, hist_d;
  logic [2:0]                db_q, db_d;
  logic [2:0]                prev_q, prev_d;
  logic [2:0]                pulse_q, pulse_d;
  logic [SAMPLES-1:0]        shifted;

  assign slow_tick = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    sync1_d = {down, up, set};
    sync2_d = sync1_q;
    hist_d  = hist_q;
    db_d    = db_q;
    shifted = '0;
    for (int i = 0; i < 3; i++) begin
      if (slow_tick) begin
        shifted   = {hist_q[i][SAMPLES-2:0], sync2_q[i]};
        hist_d[i] = shifted;
        if (&shifted) begin
          db_d[i] = 1'b1;
        end else if (~|shifted) begin
          db_d[i] = 1'b0;
        end
      end
    end
    prev_d  = db_q;
    pulse_d = db_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      db_q    <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      db_q    <= db_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign db_set     = db_q[0];
  assign db_up      = db_q[1];
  assign db_down    = db_q[2];
  assign pulse_set  = pulse_q[0];
  assign pulse_up   = pulse_q[1];
  assign pulse_down = pulse_q[2];

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed vector table plus hand sequences for button_conditioner (DIV=4, SAMPLES=3)
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset, set, up, down;
  logic slow_tick, db_set, db_up, db_down, pulse_set, pulse_up, pulse_down;

  int tests = 0;
  int fails = 0;

  button_conditioner #(.DIV(4), .SAMPLES(3)) dut (
    .clk(clk), .reset(reset), .set(set), .up(up), .down(down),
    .slow_tick(slow_tick), .db_set(db_set), .db_up(db_up), .db_down(db_down),
    .pulse_set(pulse_set), .pulse_up(pulse_up), .pulse_down(pulse_down)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] btn;   // {down, up, set}
    logic       tick;
    logic [2:0] db;
    logic [2:0] pulse;
  } vec_t;

  vec_t vecs[$];
  int   edge_n = 0;

  // Expected tick: high after non-reset edges 3, 7, 11, ... since reset
  task automatic add(input logic rst, input logic [2:0] btn, input logic [2:0] db,
                     input logic [2:0] pulse, input int count);
    vec_t v;
    for (int k = 0; k < count; k++) begin
      if (rst) edge_n = 0;
      else     edge_n++;
      v.rst   = rst;
      v.btn   = btn;
      v.tick  = !rst && ((edge_n % 4) == 3);
      v.db    = db;
      v.pulse = pulse;
      vecs.push_back(v);
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] got, want;
    int rs, rd, ps, pd, nps, npd, up_bad, set_bad;

    reset = 1'b1; set = 1'b0; up = 1'b0; down = 1'b0;

    add(1, 3'b000, 3'b000, 3'b000, 3);   // reset held
    add(0, 3'b000, 3'b000, 3'b000, 8);   // idle, ticks after edges 3 and 7
    add(0, 3'b010, 3'b000, 3'b000, 11);  // up pressed at edge 9, samples at 12,16
    add(0, 3'b010, 3'b010, 3'b000, 1);   // edge 20: third one-sample -> db_up
    add(0, 3'b010, 3'b010, 3'b010, 1);   // edge 21: single pulse
    add(0, 3'b010, 3'b010, 3'b000, 27);  // held to edge 48, no repeat pulse
    add(0, 3'b000, 3'b010, 3'b000, 11);  // released at 49, zero samples 52,56,60
    add(0, 3'b000, 3'b000, 3'b000, 5);   // edge 60: db_up falls, no pulse
    add(0, 3'b010, 3'b000, 3'b000, 4);   // bounce: samples 1,0,1,0
    add(0, 3'b000, 3'b000, 3'b000, 4);
    add(0, 3'b010, 3'b000, 3'b000, 4);
    add(0, 3'b000, 3'b000, 3'b000, 12);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      {down, up, set} = vecs[i].btn;
      step();
      got  = {slow_tick, db_down, db_up, db_set, pulse_down, pulse_up, pulse_set};
      want = {vecs[i].tick, vecs[i].db, vecs[i].pulse};
      check($sformatf("vec[%0d]", i), int'(got), int'(want));
    end

    // Simultaneous set + down presses
    set = 1'b1; down = 1'b1;
    rs = -1; rd = -1; ps = -1; pd = -1; nps = 0; npd = 0; up_bad = 0;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (db_set  && rs < 0) rs = c;
      if (db_down && rd < 0) rd = c;
      if (pulse_set)  begin nps++; if (ps < 0) ps = c; end
      if (pulse_down) begin npd++; if (pd < 0) pd = c; end
      if (db_up || pulse_up) up_bad++;
    end
    check("sim_db_set_seen", int'(rs > 0 && rs <= 15), 1);
    check("sim_db_down_same_cycle", rd, rs);
    check("sim_pulse_set_cycle", ps, rs + 1);
    check("sim_pulse_down_same_cycle", pd, ps);
    check("sim_pulse_set_count", nps, 1);
    check("sim_pulse_down_count", npd, 1);
    check("sim_up_quiet", up_bad, 0);

    // Reset while down is held and debounced
    set = 1'b0;
    step();
    step();
    check("pre_reset_db_down", int'(db_down), 1);
    reset = 1'b1;
    step();
    check("reset_edge_outputs",
          int'({slow_tick, db_down, db_up, db_set, pulse_down, pulse_up, pulse_set}), 0);
    reset = 1'b0;
    rd = -1; pd = -1; npd = 0; set_bad = 0;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (db_down && rd < 0) rd = c;
      if (pulse_down) begin npd++; if (pd < 0) pd = c; end
      if (db_set || pulse_set || db_up || pulse_up) set_bad++;
    end
    // Ticks at edges 4, 8, 12 after release all sample down=1
    check("rst_db_down_rise_cycle", rd, 12);
    check("rst_pulse_down_cycle", pd, 13);
    check("rst_pulse_down_count", npd, 1);
    check("rst_other_channels_quiet", set_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
